// File: rtl/registro_id_ex_pkg.sv
// Shared widths, ALU function codes and the EX control bundle for the ID/EX pipeline register.
package registro_id_ex_pkg;

    localparam int unsigned ANCHO_DATOS   = 32;
    localparam int unsigned ANCHO_FUNC    = 4;
    localparam int unsigned ANCHO_REG     = 5;
    localparam int unsigned ANCHO_CONTROL = 6;

    typedef enum logic [ANCHO_FUNC-1:0] {
        AluAnd = 4'b0000,
        AluOr  = 4'b0001,
        AluAdd = 4'b0010,
        AluSub = 4'b0110,
        AluSlt = 4'b0111,
        AluNor = 4'b1100
    } alu_func_e;

    // Bit order matches {reg_escribir, destino_reg, mem_escribir, mem_leer, mem_a_reg, branch}.
    typedef struct packed {
        logic reg_escribir;
        logic destino_reg;
        logic mem_escribir;
        logic mem_leer;
        logic mem_a_reg;
        logic branch;
    } control_t;

    localparam control_t CONTROL_BURBUJA = '0;

    function automatic control_t empaquetar_control(
        input logic reg_escribir,
        input logic destino_reg,
        input logic mem_escribir,
        input logic mem_leer,
        input logic mem_a_reg,
        input logic branch
    );
        control_t c;
        c.reg_escribir = reg_escribir;
        c.destino_reg  = destino_reg;
        c.mem_escribir = mem_escribir;
        c.mem_leer     = mem_leer;
        c.mem_a_reg    = mem_a_reg;
        c.branch       = branch;
        return c;
    endfunction

endpackage

// File: rtl/registro_id_ex_detector_riesgos.sv
// Load-use hazard detector: purely combinational comparison of the EX load target against
// the source registers of the instruction sitting in decode.
module detector_riesgos
    import registro_id_ex_pkg::*;
(
    input  logic                 ex_mem_leer_i,
    input  logic                 ex_valido_i,
    input  logic [ANCHO_REG-1:0] ex_rt_i,
    input  logic [ANCHO_REG-1:0] id_rs_i,
    input  logic [ANCHO_REG-1:0] id_rt_i,
    input  logic                 id_valido_i,
    input  logic                 flush_i,
    output logic                 riesgo_o
);

    logic carga_en_ex;
    logic coincide_fuente;

    always_comb begin
        // Register zero is hardwired, so a load into it never creates a dependency.
        carga_en_ex     = ex_mem_leer_i & ex_valido_i & (ex_rt_i != '0);
        coincide_fuente = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);
        riesgo_o        = carga_en_ex & coincide_fuente & id_valido_i & ~flush_i;
    end

endmodule

// File: rtl/registro_id_ex.sv
// ID/EX pipeline register with load-use stall insertion, branch flush and a saturating
// counter of inserted stall bubbles.
module registro_id_ex #(
    parameter int unsigned ANCHO_DATOS    = registro_id_ex_pkg::ANCHO_DATOS,
    parameter int unsigned ANCHO_CONTADOR = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,

    input  logic [ANCHO_DATOS-1:0]                id_dato1,
    input  logic [ANCHO_DATOS-1:0]                id_dato2,
    input  logic [ANCHO_DATOS-1:0]                id_inmediato,
    input  logic [registro_id_ex_pkg::ANCHO_FUNC-1:0] id_alu_func,
    input  logic [registro_id_ex_pkg::ANCHO_REG-1:0]  id_rs,
    input  logic [registro_id_ex_pkg::ANCHO_REG-1:0]  id_rt,
    input  logic [registro_id_ex_pkg::ANCHO_REG-1:0]  id_rd,
    input  logic                                  id_reg_escribir,
    input  logic                                  id_destino_reg,
    input  logic                                  id_mem_escribir,
    input  logic                                  id_mem_leer,
    input  logic                                  id_mem_a_reg,
    input  logic                                  id_branch,
    input  logic                                  id_valido,
    input  logic                                  flush,

    output logic [ANCHO_DATOS-1:0]                ex_dato1,
    output logic [ANCHO_DATOS-1:0]                ex_dato2,
    output logic [ANCHO_DATOS-1:0]                ex_inmediato,
    output logic [registro_id_ex_pkg::ANCHO_FUNC-1:0] ex_alu_func,
    output logic [registro_id_ex_pkg::ANCHO_REG-1:0]  ex_rt,
    output logic [registro_id_ex_pkg::ANCHO_REG-1:0]  ex_rd,
    output logic                                  ex_valido,
    output logic                                  ex_reg_escribir,
    output logic                                  ex_destino_reg,
    output logic                                  ex_mem_escribir,
    output logic                                  ex_mem_leer,
    output logic                                  ex_mem_a_reg,
    output logic                                  ex_branch,

    output logic                                  riesgo,
    output logic                                  pc_escribir,
    output logic                                  if_id_escribir,
    output logic [ANCHO_CONTADOR-1:0]             cuenta_bloqueos
);

    import registro_id_ex_pkg::*;

    logic [ANCHO_DATOS-1:0]    dato1_q,     dato1_d;
    logic [ANCHO_DATOS-1:0]    dato2_q,     dato2_d;
    logic [ANCHO_DATOS-1:0]    inmediato_q, inmediato_d;
    logic [ANCHO_FUNC-1:0]     alu_func_q,  alu_func_d;
    logic [ANCHO_REG-1:0]      rt_q,        rt_d;
    logic [ANCHO_REG-1:0]      rd_q,        rd_d;
    logic                      valido_q,    valido_d;
    control_t                  control_q,   control_d;
    logic [ANCHO_CONTADOR-1:0] cuenta_q,    cuenta_d;

    control_t id_control;
    logic     burbuja;

    detector_riesgos u_detector_riesgos (
        .ex_mem_leer_i (control_q.mem_leer),
        .ex_valido_i   (valido_q),
        .ex_rt_i       (rt_q),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_valido_i   (id_valido),
        .flush_i       (flush),
        .riesgo_o      (riesgo)
    );

    always_comb begin
        id_control = empaquetar_control(id_reg_escribir, id_destino_reg, id_mem_escribir,
                                        id_mem_leer, id_mem_a_reg, id_branch);
        burbuja    = riesgo | flush | ~id_valido;
    end

    // Bubbles clear only valid and control; the datapath words keep their previous contents.
    always_comb begin
        dato1_d     = dato1_q;
        dato2_d     = dato2_q;
        inmediato_d = inmediato_q;
        alu_func_d  = alu_func_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        valido_d    = 1'b0;
        control_d   = CONTROL_BURBUJA;

        if (!burbuja) begin
            dato1_d     = id_dato1;
            dato2_d     = id_dato2;
            inmediato_d = id_inmediato;
            alu_func_d  = id_alu_func;
            rt_d        = id_rt;
            rd_d        = id_rd;
            valido_d    = 1'b1;
            control_d   = id_control;
        end
    end

    // riesgo already excludes flush cycles, so flush bubbles never reach the counter.
    always_comb begin
        cuenta_d = cuenta_q;
        if (riesgo && (cuenta_q != '1)) begin
            cuenta_d = cuenta_q + ANCHO_CONTADOR'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dato1_q     <= '0;
            dato2_q     <= '0;
            inmediato_q <= '0;
            alu_func_q  <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            valido_q    <= 1'b0;
            control_q   <= CONTROL_BURBUJA;
            cuenta_q    <= '0;
        end else begin
            dato1_q     <= dato1_d;
            dato2_q     <= dato2_d;
            inmediato_q <= inmediato_d;
            alu_func_q  <= alu_func_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            valido_q    <= valido_d;
            control_q   <= control_d;
            cuenta_q    <= cuenta_d;
        end
    end

    always_comb begin
        ex_dato1        = dato1_q;
        ex_dato2        = dato2_q;
        ex_inmediato    = inmediato_q;
        ex_alu_func     = alu_func_q;
        ex_rt           = rt_q;
        ex_rd           = rd_q;
        ex_valido       = valido_q;
        ex_reg_escribir = control_q.reg_escribir;
        ex_destino_reg  = control_q.destino_reg;
        ex_mem_escribir = control_q.mem_escribir;
        ex_mem_leer     = control_q.mem_leer;
        ex_mem_a_reg    = control_q.mem_a_reg;
        ex_branch       = control_q.branch;
        pc_escribir     = ~riesgo;
        if_id_escribir  = ~riesgo;
        cuenta_bloqueos = cuenta_q;
    end

endmodule

// File: tb/tb_registro_id_ex.sv
// Scoreboard bench for registro_id_ex: the driver queues the expected EX contents for each
// issued cycle, a negedge monitor pops and compares them.
module tb_registro_id_ex;
    import registro_id_ex_pkg::*;

    localparam int unsigned AD = 32;
    localparam int unsigned AC = 8;

    localparam logic [5:0] C_ALU = 6'b100000;
    localparam logic [5:0] C_LW  = 6'b100110;
    localparam logic [5:0] C_BR  = 6'b000001;

    typedef struct {
        logic [AD-1:0] d1, d2, imm;
        logic [3:0]    f;
        logic [4:0]    rs, rt, rd;
        logic [5:0]    ctrl;
        logic          v;
        logic          fl;
    } stim_t;

    typedef struct {
        int            due;
        logic          v;
        logic [5:0]    ctrl;
        logic          chk_data;
        logic [AD-1:0] d1, d2, imm;
        logic [3:0]    f;
        logic [4:0]    rt, rd;
        logic [AC-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AD-1:0] id_dato1, id_dato2, id_inmediato;
    logic [3:0]    id_alu_func;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [5:0]    id_ctrl;
    logic          id_valido, flush;
    logic [AD-1:0] ex_dato1, ex_dato2, ex_inmediato;
    logic [3:0]    ex_alu_func;
    logic [4:0]    ex_rt, ex_rd;
    logic          ex_valido;
    logic          ex_reg_escribir, ex_destino_reg, ex_mem_escribir;
    logic          ex_mem_leer, ex_mem_a_reg, ex_branch;
    logic          riesgo, pc_escribir, if_id_escribir;
    logic [AC-1:0] cuenta_bloqueos;
    logic [5:0]    ex_ctrl;

    assign ex_ctrl = {ex_reg_escribir, ex_destino_reg, ex_mem_escribir,
                      ex_mem_leer, ex_mem_a_reg, ex_branch};

    registro_id_ex #(
        .ANCHO_DATOS    (AD),
        .ANCHO_CONTADOR (AC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_dato1        (id_dato1),
        .id_dato2        (id_dato2),
        .id_inmediato    (id_inmediato),
        .id_alu_func     (id_alu_func),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_reg_escribir (id_ctrl[5]),
        .id_destino_reg  (id_ctrl[4]),
        .id_mem_escribir (id_ctrl[3]),
        .id_mem_leer     (id_ctrl[2]),
        .id_mem_a_reg    (id_ctrl[1]),
        .id_branch       (id_ctrl[0]),
        .id_valido       (id_valido),
        .flush           (flush),
        .ex_dato1        (ex_dato1),
        .ex_dato2        (ex_dato2),
        .ex_inmediato    (ex_inmediato),
        .ex_alu_func     (ex_alu_func),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .ex_valido       (ex_valido),
        .ex_reg_escribir (ex_reg_escribir),
        .ex_destino_reg  (ex_destino_reg),
        .ex_mem_escribir (ex_mem_escribir),
        .ex_mem_leer     (ex_mem_leer),
        .ex_mem_a_reg    (ex_mem_a_reg),
        .ex_branch       (ex_branch),
        .riesgo          (riesgo),
        .pc_escribir     (pc_escribir),
        .if_id_escribir  (if_id_escribir),
        .cuenta_bloqueos (cuenta_bloqueos)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic [AD-1:0] d1, input logic [AD-1:0] d2,
                                 input logic [AD-1:0] imm, input logic [3:0] f,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [5:0] ctrl,
                                 input logic v, input logic fl);
        stim_t s;
        s.d1 = d1; s.d2 = d2; s.imm = imm; s.f = f;
        s.rs = rs; s.rt = rt; s.rd = rd; s.ctrl = ctrl; s.v = v; s.fl = fl;
        return s;
    endfunction

    // exp_r < 0 skips the combinational hazard checks for that cycle.
    task automatic issue(input stim_t s, input bit rst, input int exp_r, input bit bubble,
                         input int exp_cnt);
        exp_t e;
        rst_n        = !rst;
        id_dato1     = s.d1;
        id_dato2     = s.d2;
        id_inmediato = s.imm;
        id_alu_func  = s.f;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_rd        = s.rd;
        id_ctrl      = s.ctrl;
        id_valido    = s.v;
        flush        = s.fl;
        e.due = cyc + 1;
        e.cnt = AC'(exp_cnt);
        if (rst) begin
            e.v = 1'b0; e.ctrl = '0; e.chk_data = 1'b1;
            e.d1 = '0; e.d2 = '0; e.imm = '0; e.f = '0; e.rt = '0; e.rd = '0;
            e.cnt = '0;
        end else if (bubble) begin
            e.v = 1'b0; e.ctrl = '0; e.chk_data = 1'b0;
            e.d1 = '0; e.d2 = '0; e.imm = '0; e.f = '0; e.rt = '0; e.rd = '0;
        end else begin
            e.v = 1'b1; e.ctrl = s.ctrl; e.chk_data = 1'b1;
            e.d1 = s.d1; e.d2 = s.d2; e.imm = s.imm; e.f = s.f; e.rt = s.rt; e.rd = s.rd;
        end
        sb.push_back(e);
        #2;
        if (exp_r >= 0) begin
            check($sformatf("riesgo@%0d", cyc), 64'(riesgo), 64'(exp_r));
            check($sformatf("pc_escribir@%0d", cyc), 64'(pc_escribir), 64'(exp_r == 0));
            check($sformatf("if_id_escribir@%0d", cyc), 64'(if_id_escribir), 64'(exp_r == 0));
        end
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
            if (sb[0].due < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_missed: got cycle %0d expected cycle %0d", cyc, sb[0].due);
                void'(sb.pop_front());
            end else if (sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("ex_valido@%0d", cyc), 64'(ex_valido), 64'(e.v));
                check($sformatf("ex_ctrl@%0d", cyc), 64'(ex_ctrl), 64'(e.ctrl));
                check($sformatf("cuenta@%0d", cyc), 64'(cuenta_bloqueos), 64'(e.cnt));
                if (e.chk_data) begin
                    check($sformatf("ex_dato1@%0d", cyc), 64'(ex_dato1), 64'(e.d1));
                    check($sformatf("ex_dato2@%0d", cyc), 64'(ex_dato2), 64'(e.d2));
                    check($sformatf("ex_inm@%0d", cyc), 64'(ex_inmediato), 64'(e.imm));
                    check($sformatf("ex_func@%0d", cyc), 64'(ex_alu_func), 64'(e.f));
                    check($sformatf("ex_rt@%0d", cyc), 64'(ex_rt), 64'(e.rt));
                    check($sformatf("ex_rd@%0d", cyc), 64'(ex_rd), 64'(e.rd));
                end
            end
        end
    end

    initial begin
        stim_t add_a, add_b, lw8, add8, lw0, add0, lw9, add9, lw10, add10, beq, lw88;
        int    cnt;

        rst_n = 1'b0; id_dato1 = '0; id_dato2 = '0; id_inmediato = '0; id_alu_func = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_ctrl = '0; id_valido = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_valido", 64'(ex_valido), 64'd0);
        check("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
        check("rst_ex_dato1", 64'(ex_dato1), 64'd0);
        check("rst_cuenta", 64'(cuenta_bloqueos), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_riesgo", 64'(riesgo), 64'd0);
        check("post_rst_pc_escribir", 64'(pc_escribir), 64'd1);
        check("post_rst_if_id_escribir", 64'(if_id_escribir), 64'd1);

        add_a = mk(32'h5, 32'h7, 32'h0, AluAdd, 5'd1, 5'd2, 5'd3, C_ALU, 1'b1, 1'b0);
        add_b = mk(32'h5, 32'h7, 32'h4, AluAdd, 5'd3, 5'd4, 5'd5, C_ALU, 1'b1, 1'b0);
        lw8   = mk(32'h100, 32'h10, 32'h10, AluAdd, 5'd1, 5'd8, 5'd0, C_LW, 1'b1, 1'b0);
        add8  = mk(32'h11, 32'h22, 32'h0, AluAdd, 5'd8, 5'd2, 5'd9, C_ALU, 1'b1, 1'b0);
        lw0   = mk(32'h200, 32'h4, 32'h4, AluAdd, 5'd2, 5'd0, 5'd0, C_LW, 1'b1, 1'b0);
        add0  = mk(32'h33, 32'h44, 32'h0, AluAdd, 5'd0, 5'd0, 5'd6, C_ALU, 1'b1, 1'b0);
        lw9   = mk(32'h300, 32'h8, 32'h8, AluAdd, 5'd3, 5'd9, 5'd0, C_LW, 1'b1, 1'b0);
        add9  = mk(32'h55, 32'h66, 32'h0, AluAdd, 5'd9, 5'd1, 5'd7, C_ALU, 1'b1, 1'b1);
        lw10  = mk(32'h400, 32'hC, 32'hC, AluAdd, 5'd4, 5'd10, 5'd0, C_LW, 1'b1, 1'b0);
        add10 = mk(32'h77, 32'h88, 32'h0, AluAdd, 5'd10, 5'd1, 5'd11, C_ALU, 1'b0, 1'b0);
        beq   = mk(32'hAA, 32'hBB, 32'hFFFF_FFF0, AluSub, 5'd5, 5'd6, 5'd12, C_BR, 1'b1, 1'b0);
        lw88  = mk(32'h500, 32'h0, 32'h0, AluAdd, 5'd8, 5'd8, 5'd0, C_LW, 1'b1, 1'b0);

        issue(add_a, 1'b0, 0, 1'b0, 0);
        issue(add_b, 1'b0, 0, 1'b0, 0);
        issue(lw8,   1'b0, 0, 1'b0, 0);
        issue(add8,  1'b0, 1, 1'b1, 1);     // load-use stall
        issue(add8,  1'b0, 0, 1'b0, 1);     // ADD reaches EX after one bubble
        issue(lw0,   1'b0, 0, 1'b0, 1);
        issue(add0,  1'b0, 0, 1'b0, 1);     // rt=0 never stalls
        issue(lw9,   1'b0, 0, 1'b0, 1);
        issue(add9,  1'b0, 0, 1'b1, 1);     // flush wins, not counted
        issue(lw10,  1'b0, 0, 1'b0, 1);
        issue(add10, 1'b0, 0, 1'b1, 1);     // invalid slot: bubble, no hazard
        issue(beq,   1'b0, 0, 1'b0, 1);
        issue(lw88,  1'b0, 0, 1'b0, 1);

        cnt = 1;
        for (int i = 0; i < 256; i++) begin
            cnt = (cnt < 255) ? cnt + 1 : 255;
            issue(lw88, 1'b0, 1, 1'b1, cnt);
            issue(lw88, 1'b0, 0, 1'b0, cnt);
        end
        check("cuenta_saturada", 64'(cuenta_bloqueos), 64'hFF);

        issue(add8, 1'b1, -1, 1'b1, 0);     // reset during a stall cycle
        issue(add8, 1'b0, 0, 1'b0, 0);

        id_valido = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/registro_id_ex.md
REGISTRO_ID_EX -- requirements
Module: registro_id_ex

Interface
REQ-001 SHALL have parameter ANCHO_DATOS, default 32, meaning width of every datapath word.
REQ-002 SHALL have parameter ANCHO_CONTADOR, default 16, meaning width of the stall counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset: synchronous and active-low.
REQ-005 SHALL have port id_dato1, input, ANCHO_DATOS, meaning rs read data from decode.
REQ-006 SHALL have port id_dato2, input, ANCHO_DATOS, meaning ALU operand B from decode (register or immediate, already muxed).
REQ-007 SHALL have port id_inmediato, input, ANCHO_DATOS, meaning sign-extended immediate.
REQ-008 SHALL have port id_alu_func, input, 4, meaning ALU function code.
REQ-009 SHALL have ports id_rs, id_rt and id_rd, input, 5 each, meaning instruction register fields.
REQ-010 SHALL have ports id_reg_escribir, id_destino_reg, id_mem_escribir, id_mem_leer, id_mem_a_reg and id_branch, input, 1 each, meaning decode control bits.
REQ-011 SHALL have port id_valido, input, 1, meaning the decode slot holds a real instruction.
REQ-012 SHALL have port flush, input, 1, meaning branch taken in EX; squash decode slot.
REQ-013 SHALL have ports ex_dato1, ex_dato2, ex_inmediato, ex_alu_func, ex_rt, ex_rd and ex_valido, output, widths as inputs, meaning registered copies.
REQ-014 SHALL have ports ex_reg_escribir, ex_destino_reg, ex_mem_escribir, ex_mem_leer, ex_mem_a_reg and ex_branch, output, 1 each, meaning registered control bits.
REQ-015 SHALL have port riesgo, output, 1, meaning load-use stall this cycle.
REQ-016 SHALL have port pc_escribir, output, 1, meaning PC may update.
REQ-017 SHALL have port if_id_escribir, output, 1, meaning IF/ID register may update.
REQ-018 SHALL have port cuenta_bloqueos, output, ANCHO_CONTADOR, meaning number of inserted stall bubbles.

Function
REQ-019 riesgo SHALL be combinational: ex_mem_leer & ex_valido & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & id_valido & ~flush.
REQ-020 pc_escribir and if_id_escribir SHALL both equal ~riesgo.
REQ-021 Normal cycle (no riesgo, no flush) SHALL latch all id_* inputs into ex_* outputs; latency 1 cycle.
REQ-022 A riesgo cycle SHALL load a bubble: ex_valido=0 and all six control outputs=0; data outputs don't-care but SHALL be held.
REQ-023 A flush cycle SHALL load a bubble as in REQ-022 regardless of riesgo; flush has priority, so riesgo=0 and pc_escribir=1.
REQ-024 A load-use stall SHALL last exactly one cycle, because the bubble clears ex_mem_leer.
REQ-025 id_valido=0 SHALL load a bubble and SHALL NOT raise riesgo.
REQ-026 cuenta_bloqueos SHALL increment by 1 on each clock edge where riesgo=1, and SHALL saturate at all-ones with no wrap.
REQ-027 Flush bubbles SHALL NOT be counted.

Reset
REQ-028 On a clock edge with rst_n=0, all ex_* outputs and cuenta_bloqueos SHALL become 0.
REQ-029 Reset SHALL override riesgo and flush on that edge.
REQ-030 On the first cycle after reset, riesgo SHALL be 0 and pc_escribir and if_id_escribir SHALL be 1.

Structure
REQ-031 A shared package SHALL hold ANCHO_DATOS, the 4-bit ALU function codes and the control-bundle width (6).
REQ-032 Hazard comparison SHALL live in one combinational sub-module, detector_riesgos; all state SHALL stay in registro_id_ex.

Verification
REQ-033 Back-to-back ADDs, id_dato1=0x5, id_dato2=0x7, each id_valido=1 -> ex_dato1=0x5 and ex_dato2=0x7 one cycle later; riesgo stays 0.
REQ-034 LW with rt=8, then ADD with rs=8 -> riesgo=1 for one cycle; pc_escribir=0; next ex_valido=0; cuenta_bloqueos=1; ADD reaches EX on the following cycle.
REQ-035 LW with rt=0, then ADD with rs=0 -> riesgo stays 0 and no bubble is inserted.
REQ-036 Load-use condition with flush=1 in the same cycle -> riesgo=0, pc_escribir=1, bubble loaded, cuenta_bloqueos unchanged.
REQ-037 Counter preloaded to 0xFFFF by repeated stalls, then a further stall -> cuenta_bloqueos stays 0xFFFF.
REQ-038 rst_n=0 asserted mid-stall -> next edge gives all outputs 0 and cuenta_bloqueos=0; riesgo=0 on the following cycle.
